// File: rtl/sixbitdiv.sv
// sixbitdiv: sequential restoring divider that retires one quotient bit per clock.
// Define SIXBITDIV_SIGNED_EN for two's-complement (truncating) division; the default build is unsigned.
module sixbitdiv #(
    parameter int WIDTH = 6
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             dbz_o,
    output logic             overflow_o
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] divisor_q;
    logic             negQuot_q;
    logic             negRem_q;
    logic             ovf_q;

    logic [WIDTH:0]   remShift;
    logic [WIDTH+1:0] trial;
    logic [WIDTH-1:0] rem_d;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] quotFinal;
    logic [WIDTH-1:0] remFinal;
    logic [WIDTH-1:0] aMag;
    logic [WIDTH-1:0] bMag;
    logic             negQuot_d;
    logic             negRem_d;
    logic             ovf_d;

    // Shifted partial remainder can reach 2*b, so it is carried one bit wider than the operands.
    always_comb begin
        remShift = {rem_q, q_q[WIDTH-1]};
        trial    = {1'b0, remShift} + {2'b11, ~divisor_q} + (WIDTH+2)'(1);
        rem_d    = remShift[WIDTH-1:0];
        q_d      = {q_q[WIDTH-2:0], 1'b0};
        if (!trial[WIDTH+1]) begin
            rem_d = trial[WIDTH-1:0];
            q_d   = {q_q[WIDTH-2:0], 1'b1};
        end

`ifdef SIXBITDIV_SIGNED_EN
        aMag      = a_i[WIDTH-1] ? -a_i : a_i;
        bMag      = b_i[WIDTH-1] ? -b_i : b_i;
        negQuot_d = a_i[WIDTH-1] ^ b_i[WIDTH-1];
        negRem_d  = a_i[WIDTH-1];
        ovf_d     = (a_i == {1'b1, {(WIDTH-1){1'b0}}}) && (&b_i);
`else
        aMag      = a_i;
        bMag      = b_i;
        negQuot_d = 1'b0;
        negRem_d  = 1'b0;
        ovf_d     = 1'b0;
`endif

        quotFinal = negQuot_q ? -q_d : q_d;
        remFinal  = negRem_q ? -rem_d : rem_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            q_q         <= '0;
            divisor_q   <= '0;
            negQuot_q   <= 1'b0;
            negRem_q    <= 1'b0;
            ovf_q       <= 1'b0;
            quotient_o  <= '0;
            remainder_o <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            dbz_o       <= 1'b0;
            overflow_o  <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        dbz_o      <= 1'b0;
                        overflow_o <= 1'b0;
                        if (b_i == '0) begin
                            done_o      <= 1'b1;
                            dbz_o       <= 1'b1;
                            quotient_o  <= '1;
                            remainder_o <= a_i;
                        end else begin
                            rem_q     <= '0;
                            q_q       <= aMag;
                            divisor_q <= bMag;
                            negQuot_q <= negQuot_d;
                            negRem_q  <= negRem_d;
                            ovf_q     <= ovf_d;
                            cnt_q     <= '0;
                            busy_o    <= 1'b1;
                            state_q   <= RUN;
                        end
                    end
                end
                RUN: begin
                    rem_q <= rem_d;
                    q_q   <= q_d;
                    // The last iteration writes the sign-fixed result straight to the outputs.
                    if (cnt_q == LAST) begin
                        quotient_o  <= quotFinal;
                        remainder_o <= remFinal;
                        overflow_o  <= ovf_q;
                        done_o      <= 1'b1;
                        busy_o      <= 1'b0;
                        cnt_q       <= '0;
                        state_q     <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sixbitdiv.sv
// Self-checking bench for sixbitdiv: a scoreboard of expected results is filled as operations
// are issued and drained by a monitor on each done pulse; honours SIXBITDIV_SIGNED_EN.
module tb_sixbitdiv;

    localparam int WIDTH = 6;

    typedef struct {
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] r;
        logic             dbz;
        logic             ovf;
        int               doneCycle;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             busy;
    logic             done;
    logic             dbz;
    logic             overflow;

    int   cycle;
    int   checkCount;
    int   failCount;
    exp_t sb[$];

    sixbitdiv #(.WIDTH(WIDTH)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .start_i     (start),
        .a_i         (a),
        .b_i         (b),
        .quotient_o  (quotient),
        .remainder_o (remainder),
        .busy_o      (busy),
        .done_o      (done),
        .dbz_o       (dbz),
        .overflow_o  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Reference division, written from the arithmetic definition rather than the shift/subtract loop.
    function automatic exp_t model(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input int acc);
        exp_t e;
        e.dbz = 1'b0;
        e.ovf = 1'b0;
        e.doneCycle = acc + WIDTH;
        if (bv == '0) begin
            e.q = '1;
            e.r = av;
            e.dbz = 1'b1;
            e.doneCycle = acc;
        end else begin
`ifdef SIXBITDIV_SIGNED_EN
            int sa;
            int sb2;
            sa  = $signed(av);
            sb2 = $signed(bv);
            if (sa == -(2 ** (WIDTH - 1)) && sb2 == -1) begin
                e.q   = {1'b1, {(WIDTH-1){1'b0}}};
                e.r   = '0;
                e.ovf = 1'b1;
            end else begin
                e.q = WIDTH'(sa / sb2);
                e.r = WIDTH'(sa % sb2);
            end
`else
            e.q = av / bv;
            e.r = av % bv;
`endif
        end
        return e;
    endfunction

    task automatic applyStimulus(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
        a = av;
        b = bv;
        start = 1'b1;
        sb.push_back(model(av, bv, cycle + 1));
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain", sb.size(), 0);
        sb.delete();
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                checkOutput("unexpectedDone", 1, 0);
            end else begin
                e = sb.pop_front();
                checkOutput("quotient", quotient, e.q);
                checkOutput("remainder", remainder, e.r);
                checkOutput("dbz", dbz, e.dbz);
                checkOutput("overflow", overflow, e.ovf);
                checkOutput("latency", cycle, e.doneCycle);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        checkCount = 0;
        failCount = 0;
        repeat (2) @(negedge clk);
        checkOutput("rstQuotient", quotient, 0);
        checkOutput("rstRemainder", remainder, 0);
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstDone", done, 0);
        checkOutput("rstDbz", dbz, 0);
        checkOutput("rstOverflow", overflow, 0);
        rst_n = 1'b1;
        @(negedge clk);

        applyStimulus(6'd45, 6'd7);
        checkOutput("busyRun", busy, 1);
        waitIdle();
        checkOutput("busyIdle", busy, 0);
        applyStimulus(6'd63, 6'd1);
        waitIdle();
        applyStimulus(6'd5, 6'd9);
        waitIdle();

        applyStimulus(6'd10, 6'd0);
        checkOutput("busyDbz", busy, 0);
        repeat (3) @(negedge clk);
        checkOutput("busyDbzLater", busy, 0);
        checkOutput("dbzHeld", dbz, 1);
        waitIdle();

        // Start held high while running must neither disturb nor queue behind the first operation.
        applyStimulus(6'd45, 6'd7);
        a = 6'd33;
        b = 6'd2;
        start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        start = 1'b0;
        waitIdle();

        applyStimulus(6'd50, 6'd6);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 20);
        checkOutput("doneSeen", done, 1);
        applyStimulus(6'd61, 6'd5);
        waitIdle();

        applyStimulus(6'd45, 6'd7);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("abortQuotient", quotient, 0);
        checkOutput("abortRemainder", remainder, 0);
        checkOutput("abortBusy", busy, 0);
        checkOutput("abortDone", done, 0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("abortNoRun", busy, 0);
        applyStimulus(6'd20, 6'd4);
        waitIdle();

        applyStimulus(6'b101100, 6'd3);
        waitIdle();
        applyStimulus(6'd20, 6'b111101);
        waitIdle();
        applyStimulus(6'b100000, 6'b111111);
        waitIdle();
        applyStimulus(6'd0, 6'd5);
        waitIdle();
        applyStimulus(6'd63, 6'd63);
        waitIdle();

        for (int i = 0; i < 12; i++) begin
            applyStimulus(WIDTH'($urandom_range(0, 63)), WIDTH'($urandom_range(0, 63)));
            waitIdle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
